// File: rtl/dmem_responder.sv
// Single-port data memory responder: one request in flight, load/store replies after LOAD/STORE_LATENCY cycles.
// Initiator holds its level request until the one-cycle reply pulse; requests are sampled only while idle.
module dmem_responder #(
    parameter int DEPTH_WORDS   = 1024,
    parameter int LOAD_LATENCY  = 2,
    parameter int STORE_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        loadValid,
    input  logic        storeValid,
    input  logic [31:0] storeData,
    input  logic [3:0]  byteEnable,
    output logic [31:0] loadData,
    output logic        loadDataValid,
    output logic        storeComplete,
    output logic        accessFault,
    output logic        busy
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, LOAD_WAIT, STORE_WAIT} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        capture;
    logic [29:0] cap_word;
    logic [31:0] cap_data;
    logic [3:0]  cap_be;
    logic [31:0] mem [DEPTH_WORDS];
    logic [AW-1:0] mem_idx;
    logic        in_range;
    logic        done;
    logic        unused_addr_lsb;

    // Byte offset is the initiator's concern; only the word index is kept.
    assign unused_addr_lsb = ^address[1:0];
    assign mem_idx  = cap_word[AW-1:0];
    assign in_range = {2'b00, cap_word} < 32'(DEPTH_WORDS);
    assign done     = (cnt == 4'd0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            cap_word <= 30'd0;
            cap_data <= 32'd0;
            cap_be   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (capture) begin
                cap_word <= address[31:2];
                cap_data <= storeData;
                cap_be   <= byteEnable;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        capture       = 1'b0;
        loadData      = 32'd0;
        loadDataValid = 1'b0;
        storeComplete = 1'b0;
        accessFault   = 1'b0;
        busy          = 1'b0;
        case (state)
            IDLE: begin
                if (storeValid) begin
                    capture   = 1'b1;
                    cnt_nxt   = 4'(STORE_LATENCY - 1);
                    state_nxt = STORE_WAIT;
                end else if (loadValid) begin
                    capture   = 1'b1;
                    cnt_nxt   = 4'(LOAD_LATENCY - 1);
                    state_nxt = LOAD_WAIT;
                end
            end
            LOAD_WAIT: begin
                busy = 1'b1;
                if (done) begin
                    loadDataValid = 1'b1;
                    accessFault   = ~in_range;
                    loadData      = in_range ? mem[mem_idx] : 32'd0;
                    state_nxt     = IDLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            STORE_WAIT: begin
                busy = 1'b1;
                if (done) begin
                    storeComplete = 1'b1;
                    accessFault   = ~in_range;
                    state_nxt     = IDLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Commit happens on the edge that closes the storeComplete cycle; contents survive reset.
    always_ff @(posedge clock) begin
        if (state == STORE_WAIT && done && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (cap_be[i]) mem[mem_idx][8*i +: 8] <= cap_data[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder: two instances (default and slow/small) against a word-array reference model.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [31:0] addr0 = '0, sd0 = '0, ld0;
    logic        lv0 = 1'b0, sv0 = 1'b0, ldv0, sc0, af0, busy0;
    logic [3:0]  be0 = '0;
    logic [31:0] addr1 = '0, sd1 = '0, ld1;
    logic        lv1 = 1'b0, sv1 = 1'b0, ldv1, sc1, af1, busy1;
    logic [3:0]  be1 = '0;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [31:0] model0 [int];
    logic [31:0] model1 [int];

    always #5 clk = ~clk;

    dmem_responder u0 (
        .clock(clk), .reset(rst), .address(addr0), .loadValid(lv0), .storeValid(sv0),
        .storeData(sd0), .byteEnable(be0), .loadData(ld0), .loadDataValid(ldv0),
        .storeComplete(sc0), .accessFault(af0), .busy(busy0)
    );

    dmem_responder #(.DEPTH_WORDS(16), .LOAD_LATENCY(4), .STORE_LATENCY(3)) u1 (
        .clock(clk), .reset(rst), .address(addr1), .loadValid(lv1), .storeValid(sv1),
        .storeData(sd1), .byteEnable(be1), .loadData(ld1), .loadDataValid(ldv1),
        .storeComplete(sc1), .accessFault(af1), .busy(busy1)
    );

    // One complete request/response exchange on instance u, checked against the model.
    task automatic access(input bit u, input bit st, input bit both, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be, input bit perturb,
                          output logic [31:0] got);
        int lat, depth, idx;
        bit inr, seen;
        logic [31:0] exp_ld, w, o_ld;
        logic o_ldv, o_sc, o_af, o_busy;
        lat   = st ? (u ? 3 : 1) : (u ? 4 : 2);
        depth = u ? 16 : 1024;
        idx   = int'(a[31:2]);
        inr   = idx < depth;
        exp_ld = 32'd0;
        if (!st && inr) exp_ld = u ? model1[idx] : model0[idx];
        got = 32'd0;

        @(negedge clk);
        total_cnt++;
        if ((u ? busy1 : busy0) !== 1'b0) $display("FAIL idle_busy u%0d: got %b want 0", u, u ? busy1 : busy0);
        else pass_cnt++;
        if (u) begin addr1 = a; sv1 = st; lv1 = !st || both; sd1 = d; be1 = be; end
        else   begin addr0 = a; sv0 = st; lv0 = !st || both; sd0 = d; be0 = be; end

        seen = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            if (perturb && k == 1) begin
                if (u) begin addr1 = a + 32'd4; sd1 = ~d; be1 = 4'hF; end
                else   begin addr0 = a + 32'd4; sd0 = ~d; be0 = 4'hF; end
            end
            o_ld = u ? ld1 : ld0;  o_ldv = u ? ldv1 : ldv0;  o_sc = u ? sc1 : sc0;
            o_af = u ? af1 : af0;  o_busy = u ? busy1 : busy0;
            if (o_ldv || o_sc) begin
                seen = 1;
                got = o_ld;
                total_cnt++;
                if (k != lat) $display("FAIL latency u%0d a=%h: got %0d want %0d", u, a, k, lat);
                else pass_cnt++;
                total_cnt++;
                if ({o_ldv, o_sc} !== (st ? 2'b01 : 2'b10))
                    $display("FAIL pulse_kind u%0d a=%h: got ldv/sc=%b%b store=%0d", u, a, o_ldv, o_sc, st);
                else pass_cnt++;
                total_cnt++;
                if (o_af !== ~inr) $display("FAIL fault u%0d a=%h: got %b want %b", u, a, o_af, ~inr);
                else pass_cnt++;
                total_cnt++;
                if (o_ld !== exp_ld) $display("FAIL load_data u%0d a=%h: got %h want %h", u, a, o_ld, exp_ld);
                else pass_cnt++;
            end else begin
                total_cnt++;
                if ({o_busy, o_af, o_ld} !== {1'b1, 1'b0, 32'h0})
                    $display("FAIL wait_outputs u%0d a=%h k=%0d: busy=%b af=%b ld=%h", u, a, k, o_busy, o_af, o_ld);
                else pass_cnt++;
            end
        end
        if (!seen) begin
            total_cnt++;
            $display("FAIL timeout u%0d a=%h: no response within 20 cycles", u, a);
        end
        if (u) begin sv1 = 0; lv1 = 0; end
        else   begin sv0 = 0; lv0 = 0; end

        if (st && inr) begin
            w = u ? model1[idx] : model0[idx];
            for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = d[8*i +: 8];
            if (u) model1[idx] = w; else model0[idx] = w;
        end
    endtask

    task automatic test_reset;
        #2;
        total_cnt++;
        if ({busy0, ldv0, sc0, af0, ld0} !== 36'h0)
            $display("FAIL reset_outputs: got busy=%b ldv=%b sc=%b af=%b ld=%h want all 0", busy0, ldv0, sc0, af0, ld0);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_full_word;
        logic [31:0] g;
        access(0, 1, 0, 32'h10, 32'hDEADBEEF, 4'hF, 0, g);
        access(0, 0, 0, 32'h10, 32'h0, 4'h0, 0, g);
        total_cnt++;
        if (g !== 32'hDEADBEEF) $display("FAIL full_word: got %h want deadbeef", g);
        else pass_cnt++;
    endtask

    task automatic test_byte_enable;
        logic [31:0] g;
        access(0, 1, 0, 32'h20, 32'h11223344, 4'hF, 0, g);
        access(0, 1, 0, 32'h20, 32'hAABBCCDD, 4'b0101, 0, g);
        access(0, 0, 0, 32'h20, 32'h0, 4'h0, 0, g);
        total_cnt++;
        if (g !== 32'h11BB33DD) $display("FAIL byte_enable: got %h want 11bb33dd", g);
        else pass_cnt++;
        access(0, 0, 0, 32'h23, 32'h0, 4'h0, 0, g);
        total_cnt++;
        if (g !== 32'h11BB33DD) $display("FAIL addr_lsb_ignored: got %h want 11bb33dd", g);
        else pass_cnt++;
        access(0, 1, 0, 32'h20, 32'hFFFFFFFF, 4'h0, 0, g);
        access(0, 0, 0, 32'h20, 32'h0, 4'h0, 0, g);
        total_cnt++;
        if (g !== 32'h11BB33DD) $display("FAIL be_zero: got %h want 11bb33dd", g);
        else pass_cnt++;
    endtask

    task automatic test_priority;
        logic [31:0] g;
        access(0, 1, 1, 32'h30, 32'h5, 4'hF, 0, g);
        access(0, 0, 0, 32'h30, 32'h0, 4'h0, 0, g);
        total_cnt++;
        if (g !== 32'h5) $display("FAIL store_priority: got %h want 5", g);
        else pass_cnt++;
    endtask

    task automatic test_fault;
        logic [31:0] g;
        access(0, 1, 0, 32'h0, 32'hCAFEF00D, 4'hF, 0, g);
        access(0, 0, 0, 32'h1000, 32'h0, 4'h0, 0, g);
        access(0, 1, 0, 32'h1000, 32'h12345678, 4'hF, 0, g);
        access(0, 0, 0, 32'h0, 32'h0, 4'h0, 0, g);
        total_cnt++;
        if (g !== 32'hCAFEF00D) $display("FAIL fault_no_write: got %h want cafef00d", g);
        else pass_cnt++;
    endtask

    task automatic test_random;
        logic [31:0] g, a;
        int idx;
        for (int i = 0; i < 16; i++) access(0, 1, 0, i * 4, $urandom, 4'hF, 0, g);
        for (int n = 0; n < 60; n++) begin
            idx = ($urandom_range(0, 9) == 0) ? 1024 + $urandom_range(0, 3) : $urandom_range(0, 15);
            a = {idx[29:0], 2'($urandom)};
            access(0, $urandom_range(0, 1) == 1, 0, a, $urandom, 4'($urandom_range(0, 15)), 0, g);
        end
    endtask

    task automatic test_back_to_back;
        int pulses;
        pulses = 0;
        @(negedge clk);
        addr0 = 32'h10; lv0 = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (ldv0) begin
                pulses++;
                total_cnt++;
                if (ld0 !== model0[4]) $display("FAIL b2b_data: got %h want %h", ld0, model0[4]);
                else pass_cnt++;
            end
        end
        lv0 = 1'b0;
        total_cnt++;
        if (pulses != 2) $display("FAIL b2b_pulses: got %0d want 2", pulses);
        else pass_cnt++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_store_latency;
        logic [31:0] g;
        access(1, 1, 0, 32'hC, 32'h77777777, 4'hF, 0, g);
        access(1, 1, 0, 32'h8, 32'h0BADC0DE, 4'hF, 1, g);
        access(1, 0, 0, 32'h8, 32'h0, 4'h0, 0, g);
        total_cnt++;
        if (g !== 32'h0BADC0DE) $display("FAIL captured_addr: got %h want 0badc0de", g);
        else pass_cnt++;
        access(1, 0, 0, 32'hC, 32'h0, 4'h0, 0, g);
        total_cnt++;
        if (g !== 32'h77777777) $display("FAIL other_addr_untouched: got %h want 77777777", g);
        else pass_cnt++;
    endtask

    task automatic test_reset_abort;
        int pulses;
        logic [31:0] g;
        @(negedge clk);
        addr1 = 32'h8; lv1 = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (busy1 !== 1'b1) $display("FAIL abort_busy_before: got %b want 1", busy1);
        else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({busy1, ldv1, af1, ld1} !== 35'h0)
            $display("FAIL async_reset: busy=%b ldv=%b af=%b ld=%h want all 0", busy1, ldv1, af1, ld1);
        else pass_cnt++;
        lv1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ldv1 || busy1) pulses++;
        end
        total_cnt++;
        if (pulses != 0) $display("FAIL abort_load: got %0d active cycles want 0", pulses);
        else pass_cnt++;

        @(negedge clk);
        addr1 = 32'h8; sv1 = 1'b1; sd1 = 32'h99999999; be1 = 4'hF;
        @(negedge clk);
        rst = 1'b1;
        sv1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (sc1) pulses++;
        end
        total_cnt++;
        if (pulses != 0) $display("FAIL abort_store: got %0d completions want 0", pulses);
        else pass_cnt++;
        access(1, 0, 0, 32'h8, 32'h0, 4'h0, 0, g);
        total_cnt++;
        if (g !== 32'h0BADC0DE) $display("FAIL abort_no_write: got %h want 0badc0de", g);
        else pass_cnt++;
        access(0, 0, 0, 32'h0, 32'h0, 4'h0, 0, g);
        total_cnt++;
        if (g !== model0[0]) $display("FAIL mem_survives_reset: got %h want %h", g, model0[0]);
        else pass_cnt++;
    endtask

    initial begin
        test_reset;
        test_full_word;
        test_byte_enable;
        test_priority;
        test_fault;
        test_random;
        test_back_to_back;
        test_store_latency;
        test_reset_abort;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
